mont_mul_pipe: RTL and testbench

- Pipelined Montgomery modular multiplier for the NTT butterfly datapath.
- Computes out = in1 * in2 * R^-1 mod p, where R = 2^DATAWIDTH.
- Modulus p, its negation p_neg and Montgomery constant mu are runtime inputs, not hard-wired.
- Single clock domain; valid-tagged stream with no backpressure.

---
 rtl/mont_mul_pipe.sv | 131 +++++++++++++
 tb/tb_mont_mul_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mont_mul_pipe.sv
// Montgomery modular multiplier: out = in1 * in2 * R^-1 mod p, with R = 2^DATAWIDTH.
// Optional macro MM_PIPE_EN selects a 3-stage pipeline (latency 3); otherwise latency 1.
module mont_mul_pipe #(
  parameter int DATAWIDTH = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [DATAWIDTH-1:0] in1,
  input  logic [DATAWIDTH-1:0] in2,
  input  logic [DATAWIDTH-1:0] mu,
  input  logic [DATAWIDTH-1:0] p,
  input  logic [DATAWIDTH-1:0] p_neg,
  output logic                 out_valid,
  output logic [DATAWIDTH-1:0] out
);

  localparam int W = DATAWIDTH;

  // Full-width product of the two operands.
  function automatic logic [2*W-1:0] calc_t(input logic [W-1:0] a_v, input logic [W-1:0] b_v);
    calc_t = {{W{1'b0}}, a_v} * {{W{1'b0}}, b_v};
  endfunction

  // m = (t mod R) * mu mod R; truncation to W bits is the mod R.
  function automatic logic [W-1:0] calc_m(input logic [2*W-1:0] t_v, input logic [W-1:0] mu_v);
    logic [W-1:0] t_lo;
    t_lo   = t_v[W-1:0];
    calc_m = t_lo * mu_v;
  endfunction

  // u = (t + m*p) >> W, then a single conditional subtraction of p.
  function automatic logic [W-1:0] calc_reduce(input logic [2*W-1:0] t_v,
                                               input logic [W-1:0]   m_v,
                                               input logic [W-1:0]   p_v,
                                               input logic [W-1:0]   pn_v);
    logic [2*W-1:0] mp;
    logic [W:0]     u;
    logic [W-1:0]   u_lo;
    logic [W-1:0]   sub;
    mp   = {{W{1'b0}}, m_v} * {{W{1'b0}}, p_v};
    u    = (W+1)'(({1'b0, t_v} + {1'b0, mp}) >> W);
    u_lo = u[W-1:0];
    sub  = u_lo + pn_v;
    if (u >= {1'b0, p_v}) begin
      calc_reduce = sub;
    end else begin
      calc_reduce = u_lo;
    end
  endfunction

`ifdef MM_PIPE_EN

  logic [2*W-1:0] t_s;
  logic [2*W-1:0] t_r1;
  logic           v_r1;
  logic [W-1:0]   m_s;
  logic [2*W-1:0] t_r2;
  logic [W-1:0]   m_r2;
  logic           v_r2;
  logic [W-1:0]   red_s;

  // Per-stage combinational arithmetic feeding the pipeline registers.
  always_comb begin
    t_s   = calc_t(in1, in2);
    m_s   = calc_m(t_r1, mu);
    red_s = calc_reduce(t_r2, m_r2, p, p_neg);
  end

  // Stage 1: product t and its valid tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_r1 <= {(2*W){1'b0}};
      v_r1 <= 1'b0;
    end else begin
      t_r1 <= t_s;
      v_r1 <= in_valid;
    end
  end

  // Stage 2: m alongside the carried product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_r2 <= {(2*W){1'b0}};
      m_r2 <= {W{1'b0}};
      v_r2 <= 1'b0;
    end else begin
      t_r2 <= t_r1;
      m_r2 <= m_s;
      v_r2 <= v_r1;
    end
  end

  // Stage 3: reduced, conditionally subtracted result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= {W{1'b0}};
      out_valid <= 1'b0;
    end else begin
      out       <= red_s;
      out_valid <= v_r2;
    end
  end

`else

  logic [2*W-1:0] t_s;
  logic [W-1:0]   m_s;
  logic [W-1:0]   red_s;

  // Whole reduction in one combinational cone.
  always_comb begin
    t_s   = calc_t(in1, in2);
    m_s   = calc_m(t_s, mu);
    red_s = calc_reduce(t_s, m_s, p, p_neg);
  end

  // Single output register with its valid tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= {W{1'b0}};
      out_valid <= 1'b0;
    end else begin
      out       <= red_s;
      out_valid <= in_valid;
    end
  end

`endif

endmodule

// File: tb/tb_mont_mul_pipe.sv
// Scoreboard bench for mont_mul_pipe: a 14-bit and a 30-bit instance against a modular-arithmetic model.
module tb_mont_mul_pipe;

`ifdef MM_PIPE_EN
  localparam int L = 3;
`else
  localparam int L = 1;
`endif
  localparam int WA = 14;
  localparam int WB = 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_vi, a_vo;
  logic [WA-1:0] a_in1, a_in2, a_mu, a_p, a_pn, a_out;
  logic          b_vi, b_vo;
  logic [WB-1:0] b_in1, b_in2, b_mu, b_p, b_pn, b_out;

  mont_mul_pipe #(.DATAWIDTH(WA)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_vi), .in1(a_in1), .in2(a_in2),
    .mu(a_mu), .p(a_p), .p_neg(a_pn), .out_valid(a_vo), .out(a_out));

  mont_mul_pipe #(.DATAWIDTH(WB)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_vi), .in1(b_in1), .in2(b_in2),
    .mu(b_mu), .p(b_p), .p_neg(b_pn), .out_valid(b_vo), .out(b_out));

  typedef struct packed {
    logic [63:0] val;
    logic [31:0] due;
  } exp_t;

  exp_t   qa[$];
  exp_t   qb[$];
  exp_t   ea, eb;
  int     cyc = 0;
  int     checks = 0;
  int     fails = 0;
  longint pa = 64'd12289;
  longint pb = 64'd343576577;
  longint rinv_a, rinv_b;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint modinv(input longint a, input longint m);
    longint t, nt, r, nr, q, tmp;
    t = 0; nt = 1; r = m; nr = a;
    while (nr != 0) begin
      q = r / nr;
      tmp = t - q * nt; t = nt; nt = tmp;
      tmp = r - q * nr; r = nr; nr = tmp;
    end
    if (t < 0) t = t + m;
    return t;
  endfunction

  // -p^-1 mod 2^w by Newton iteration on the 2-adic inverse.
  function automatic longint neg_inv(input longint pv, input int w);
    longint msk, inv;
    msk = (longint'(1) << w) - 1;
    inv = pv;
    for (int i = 0; i < 6; i++) inv = (inv * (2 - pv * inv)) & msk;
    return (-inv) & msk;
  endfunction

  function automatic longint model(input longint x, input longint y, input longint pv, input longint rinv);
    return (((x * y) % pv) * rinv) % pv;
  endfunction

  // Monitor for the 14-bit instance.
  always @(negedge clk) begin
    if (a_vo) begin
      if (qa.size() == 0) begin
        checks++; fails++;
        $display("FAIL a_spurious_valid: out_valid=1 at cycle %0d, required 0", cyc);
      end else begin
        ea = qa.pop_front();
        checks += 3;
        if (longint'(a_out) != longint'(ea.val)) begin
          fails++;
          $display("FAIL a_data: out=%0d required %0d (cycle %0d)", a_out, ea.val, cyc);
        end
        if (cyc != int'(ea.due)) begin
          fails++;
          $display("FAIL a_latency: result at cycle %0d required cycle %0d", cyc, ea.due);
        end
        if (longint'(a_out) >= pa) begin
          fails++;
          $display("FAIL a_range: out=%0d required < %0d", a_out, pa);
        end
      end
    end else if (qa.size() != 0 && cyc >= int'(qa[0].due)) begin
      ea = qa.pop_front();
      checks++; fails++;
      $display("FAIL a_missing_valid: out_valid=0 at cycle %0d, required 1 (expected %0d)", cyc, ea.val);
    end
  end

  // Monitor for the 30-bit instance.
  always @(negedge clk) begin
    if (b_vo) begin
      if (qb.size() == 0) begin
        checks++; fails++;
        $display("FAIL b_spurious_valid: out_valid=1 at cycle %0d, required 0", cyc);
      end else begin
        eb = qb.pop_front();
        checks += 3;
        if (longint'(b_out) != longint'(eb.val)) begin
          fails++;
          $display("FAIL b_data: out=%0d required %0d (cycle %0d)", b_out, eb.val, cyc);
        end
        if (cyc != int'(eb.due)) begin
          fails++;
          $display("FAIL b_latency: result at cycle %0d required cycle %0d", cyc, eb.due);
        end
        if (longint'(b_out) >= pb) begin
          fails++;
          $display("FAIL b_range: out=%0d required < %0d", b_out, pb);
        end
      end
    end else if (qb.size() != 0 && cyc >= int'(qb[0].due)) begin
      eb = qb.pop_front();
      checks++; fails++;
      $display("FAIL b_missing_valid: out_valid=0 at cycle %0d, required 1 (expected %0d)", cyc, eb.val);
    end
  end

  task automatic issue_a(input logic v, input longint x, input longint y, input longint e);
    @(negedge clk);
    a_vi  = v;
    a_in1 = WA'(x);
    a_in2 = WA'(y);
    b_vi  = 1'b0;
    if (v) qa.push_back('{val: 64'(e), due: 32'(cyc + L)});
  endtask

  task automatic issue_b(input logic v, input longint x, input longint y, input longint e);
    @(negedge clk);
    b_vi  = v;
    b_in1 = WB'(x);
    b_in2 = WB'(y);
    a_vi  = 1'b0;
    if (v) qb.push_back('{val: 64'(e), due: 32'(cyc + L)});
  endtask

  task automatic rand_a(input logic v);
    longint x, y;
    x = longint'($urandom_range(0, 12288));
    y = longint'($urandom_range(0, 12288));
    issue_a(v, x, y, model(x, y, pa, rinv_a));
  endtask

  task automatic check_zero(input string name, input longint act);
    checks++;
    if (act != 0) begin
      fails++;
      $display("FAIL %s: value=%0d required 0", name, act);
    end
  endtask

  initial begin
    longint x, y;
    a_vi = 1'b0; a_in1 = '0; a_in2 = '0;
    b_vi = 1'b0; b_in1 = '0; b_in2 = '0;
    a_p  = WA'(pa); a_pn = WA'((longint'(1) << WA) - pa); a_mu = WA'(neg_inv(pa, WA));
    b_p  = WB'(pb); b_pn = WB'((longint'(1) << WB) - pb); b_mu = WB'(neg_inv(pb, WB));
    rinv_a = modinv((longint'(1) << WA) % pa, pa);
    rinv_b = modinv((longint'(1) << WB) % pb, pb);

    repeat (2) @(negedge clk);
    check_zero("reset_a_out", longint'(a_out));
    check_zero("reset_a_valid", longint'(a_vo));
    check_zero("reset_b_out", longint'(b_out));
    check_zero("reset_b_valid", longint'(b_vo));
    @(negedge clk);
    rst_n = 1'b1;

    // Boundaries, identity and one out-of-contract input with a*b < p*R.
    issue_a(1'b1, 12288, 12288, 9216);
    issue_a(1'b1, 0, 0, 0);
    issue_a(1'b1, 1, 1, 9216);
    issue_a(1'b1, 1, 4095, 1);
    issue_a(1'b1, 5000, 4095, 5000);
    issue_a(1'b1, 0, 12288, 0);
    issue_a(1'b1, 16383, 3, model(16383, 3, pa, rinv_a));
    repeat (L + 2) issue_a(1'b0, 0, 0, 0);

    // Bubble pattern 1,0,1,1,0 repeated.
    for (int r = 0; r < 4; r++) begin
      rand_a(1'b1); rand_a(1'b0); rand_a(1'b1); rand_a(1'b1); rand_a(1'b0);
    end

    // Asynchronous reset with data in flight.
    for (int i = 0; i < 4; i++) rand_a(1'b1);
    #2;
    a_vi  = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("midreset_a_out", longint'(a_out));
    check_zero("midreset_a_valid", longint'(a_vo));
    qa.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (L + 4) issue_a(1'b0, 0, 0, 0);

    // Back-to-back throughput.
    for (int i = 0; i < 1000; i++) rand_a(1'b1);
    repeat (L + 2) issue_a(1'b0, 0, 0, 0);

    // 30-bit modulus.
    issue_b(1'b1, pb - 1, pb - 1, model(pb - 1, pb - 1, pb, rinv_b));
    issue_b(1'b1, 1, 1, rinv_b);
    issue_b(1'b1, 0, 7, 0);
    for (int i = 0; i < 1000; i++) begin
      x = longint'($urandom_range(0, 343576576));
      y = longint'($urandom_range(0, 343576576));
      issue_b(($urandom_range(0, 7) != 0), x, y, model(x, y, pb, rinv_b));
    end
    repeat (L + 3) issue_b(1'b0, 0, 0, 0);

    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      fails++;
      $display("FAIL drain: pending results a=%0d b=%0d, required 0", qa.size(), qb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
